// File: rtl/cook_timer_core.sv
// Oven cook timer: accepts LOAD/START/PAUSE/CLEAR commands, counts mm:ss down on a
// prescaled tick, pulses done at 0:00 and flashes the end-of-cook LED before reloading.
module cook_timer_core #(
  parameter int TICK_DIV    = 100000000,
  parameter int FLASH_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  output logic [6:0] rem_min,
  output logic [5:0] rem_sec,
  output logic       running,
  output logic       flash,
  output logic       done,
  output logic       cmd_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {IDLE, LOADED, RUN, PAUSED, FLASH} state_t;

  state_t          state, state_n;
  logic [6:0]      set_min, set_min_n, rem_min_n;
  logic [5:0]      set_sec, set_sec_n, rem_sec_n;
  logic [PW-1:0]   prescaler, prescaler_n;
  logic [FW-1:0]   flash_cnt, flash_cnt_n;
  logic            flash_n, done_n, cmd_err_n;

  logic            accept, tick, rem_zero, dec_zero;
  logic [6:0]      clamp_min, dec_min;
  logic [5:0]      clamp_sec, dec_sec;

  assign accept    = cmd_valid && cmd_ready;
  assign tick      = ((state == RUN) || (state == FLASH)) && (prescaler == TICK_LAST);
  assign clamp_min = (load_min > 7'd99) ? 7'd99 : load_min;
  assign clamp_sec = (load_sec > 6'd59) ? 6'd59 : load_sec;
  assign rem_zero  = (rem_min == 7'd0) && (rem_sec == 6'd0);
  assign dec_min   = ((rem_sec == 6'd0) && (rem_min != 7'd0)) ? rem_min - 7'd1 : rem_min;
  assign dec_sec   = (rem_sec == 6'd0) ? ((rem_min != 7'd0) ? 6'd59 : 6'd0) : rem_sec - 6'd1;
  assign dec_zero  = (dec_min == 7'd0) && (dec_sec == 6'd0);
  assign running   = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      set_min   <= '0;
      set_sec   <= '0;
      rem_min   <= '0;
      rem_sec   <= '0;
      prescaler <= '0;
      flash_cnt <= '0;
      flash     <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      set_min   <= set_min_n;
      set_sec   <= set_sec_n;
      rem_min   <= rem_min_n;
      rem_sec   <= rem_sec_n;
      prescaler <= prescaler_n;
      flash_cnt <= flash_cnt_n;
      flash     <= flash_n;
      done      <= done_n;
      cmd_err   <= cmd_err_n;
      cmd_ready <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    set_min_n   = set_min;
    set_sec_n   = set_sec;
    rem_min_n   = rem_min;
    rem_sec_n   = rem_sec;
    prescaler_n = prescaler;
    flash_cnt_n = flash_cnt;
    flash_n     = flash;
    done_n      = 1'b0;
    cmd_err_n   = 1'b0;

    if ((state == RUN) || (state == FLASH))
      prescaler_n = tick ? '0 : prescaler + 1'b1;

    case (state)
      IDLE, LOADED, PAUSED: begin
        if (accept) begin
          case (cmd)
            CMD_LOAD: begin
              set_min_n = clamp_min;
              set_sec_n = clamp_sec;
              rem_min_n = clamp_min;
              rem_sec_n = clamp_sec;
              state_n   = LOADED;
            end
            CMD_START: begin
              if (state == PAUSED) begin
                state_n = RUN;
              end else if ((state == LOADED) && !rem_zero) begin
                state_n     = RUN;
                prescaler_n = '0;
              end else begin
                cmd_err_n = 1'b1;
              end
            end
            CMD_PAUSE: cmd_err_n = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (tick) begin
          rem_min_n = dec_min;
          rem_sec_n = dec_sec;
          if (dec_zero) begin
            state_n     = FLASH;
            done_n      = 1'b1;
            flash_n     = 1'b1;
            flash_cnt_n = '0;
          end
        end
        // A PAUSE that collides with the final decrement is dropped silently.
        if (accept) begin
          if ((cmd == CMD_LOAD) || (cmd == CMD_START))
            cmd_err_n = 1'b1;
          else if ((cmd == CMD_PAUSE) && !(tick && dec_zero))
            state_n = PAUSED;
        end
      end
      FLASH: begin
        if (tick) begin
          if (flash_cnt == FLASH_LAST) begin
            flash_n     = 1'b0;
            flash_cnt_n = '0;
            rem_min_n   = set_min;
            rem_sec_n   = set_sec;
            state_n     = LOADED;
          end else begin
            flash_n     = !flash;
            flash_cnt_n = flash_cnt + 1'b1;
          end
        end
        if (accept && (cmd != CMD_CLEAR))
          cmd_err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (accept && (cmd == CMD_CLEAR)) begin
      state_n     = IDLE;
      set_min_n   = '0;
      set_sec_n   = '0;
      rem_min_n   = '0;
      rem_sec_n   = '0;
      prescaler_n = '0;
      flash_cnt_n = '0;
      flash_n     = 1'b0;
      done_n      = 1'b0;
      cmd_err_n   = 1'b0;
    end
  end

endmodule

// File: tb/tb_cook_timer_core.sv
// Directed bench for cook_timer_core with TICK_DIV=4, FLASH_TICKS=4; each task drives one
// scenario and checks hand-computed values one cycle after the relevant clock edge.
module tb_cook_timer_core;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [6:0] rem_min;
  logic [5:0] rem_sec;
  logic       running;
  logic       flash;
  logic       done;
  logic       cmd_err;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int flash_count = 0;

  cook_timer_core #(.TICK_DIV(4), .FLASH_TICKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .load_min(load_min), .load_sec(load_sec), .rem_min(rem_min), .rem_sec(rem_sec),
    .running(running), .flash(flash), .done(done), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_count++;
    if (flash) flash_count++;
  end

  // Command is presented at a falling edge, accepted on the next rising edge; returns 1 ns later.
  task automatic send(input logic [1:0] c, input logic [6:0] m, input logic [5:0] s);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    load_min  = m;
    load_sec  = s;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; load_min = '0; load_sec = '0;
    #2;
    checks++;
    if ({rem_min, rem_sec, running, flash, done, cmd_err, cmd_ready} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rem=%0d:%0d run=%b fl=%b dn=%b err=%b rdy=%b expected all 0",
               rem_min, rem_sec, running, flash, done, cmd_err, cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL ready_in_reset: got %b expected 0", cmd_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_after_reset: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_count;
    send(2'b00, 7'd1, 6'd2);
    checks++;
    if (rem_min !== 7'd1 || rem_sec !== 6'd2 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL load_1_02: got %0d:%0d run=%b expected 1:2 run=0", rem_min, rem_sec, running);
    end
    send(2'b01, 7'd0, 6'd0);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("[TB] FAIL start_running: got %b expected 1", running);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (rem_min !== 7'd1 || rem_sec !== 6'd2) begin
      errors++; $display("[TB] FAIL before_first_tick: got %0d:%0d expected 1:2", rem_min, rem_sec);
    end
    @(posedge clk); #1;
    checks++;
    if (rem_min !== 7'd1 || rem_sec !== 6'd1) begin
      errors++; $display("[TB] FAIL first_tick: got %0d:%0d expected 1:1", rem_min, rem_sec);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rem_min !== 7'd1 || rem_sec !== 6'd0) begin
      errors++; $display("[TB] FAIL second_tick: got %0d:%0d expected 1:0", rem_min, rem_sec);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rem_min !== 7'd0 || rem_sec !== 6'd59 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL minute_borrow: got %0d:%0d run=%b expected 0:59 run=1", rem_min, rem_sec, running);
    end
    send(2'b11, 7'd0, 6'd0);
    checks++;
    if (rem_min !== 7'd0 || rem_sec !== 6'd0 || running !== 1'b0 || cmd_err !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_in_run: got %0d:%0d run=%b err=%b expected 0:0 run=0 err=0", rem_min, rem_sec, running, cmd_err);
    end
  endtask

  task automatic test_done_flash;
    int d0;
    d0 = done_count;
    send(2'b00, 7'd0, 6'd2);
    send(2'b01, 7'd0, 6'd0);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rem_sec !== 6'd1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL flash_pre: got sec=%0d done=%b expected 1 done=0", rem_sec, done);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rem_min !== 7'd0 || rem_sec !== 6'd0 || done !== 1'b1 || flash !== 1'b1 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL reach_zero: got %0d:%0d done=%b fl=%b run=%b expected 0:0 done=1 fl=1 run=0",
                         rem_min, rem_sec, done, flash, running);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || flash !== 1'b1) begin
      errors++; $display("[TB] FAIL done_one_cycle: got done=%b fl=%b expected done=0 fl=1", done, flash);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (flash !== 1'b0) begin
      errors++; $display("[TB] FAIL flash_tick1: got %b expected 0", flash);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (flash !== 1'b1) begin
      errors++; $display("[TB] FAIL flash_tick2: got %b expected 1", flash);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (flash !== 1'b0 || rem_sec !== 6'd0) begin
      errors++; $display("[TB] FAIL flash_tick3: got fl=%b sec=%0d expected fl=0 sec=0", flash, rem_sec);
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rem_min !== 7'd0 || rem_sec !== 6'd2 || flash !== 1'b0 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL flash_reload: got %0d:%0d fl=%b run=%b expected 0:2 fl=0 run=0",
                         rem_min, rem_sec, flash, running);
    end
    checks++;
    if (done_count - d0 !== 1) begin
      errors++; $display("[TB] FAIL done_pulse_count: got %0d expected 1", done_count - d0);
    end
    send(2'b01, 7'd0, 6'd0);
    checks++;
    if (running !== 1'b1 || cmd_err !== 1'b0) begin
      errors++; $display("[TB] FAIL restart_after_flash: got run=%b err=%b expected run=1 err=0", running, cmd_err);
    end
    send(2'b11, 7'd0, 6'd0);
  endtask

  task automatic test_pause;
    send(2'b00, 7'd0, 6'd5);
    send(2'b01, 7'd0, 6'd0);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rem_sec !== 6'd4) begin
      errors++; $display("[TB] FAIL pause_first_dec: got %0d expected 4", rem_sec);
    end
    @(posedge clk);
    send(2'b10, 7'd0, 6'd0);
    checks++;
    if (running !== 1'b0 || cmd_err !== 1'b0 || rem_sec !== 6'd4) begin
      errors++; $display("[TB] FAIL pause_enter: got run=%b err=%b sec=%0d expected run=0 err=0 sec=4", running, cmd_err, rem_sec);
    end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (rem_min !== 7'd0 || rem_sec !== 6'd4 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL pause_hold: got %0d:%0d run=%b expected 0:4 run=0", rem_min, rem_sec, running);
    end
    send(2'b01, 7'd0, 6'd0);
    @(posedge clk); #1;
    checks++;
    if (rem_sec !== 6'd4 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL resume_early: got sec=%0d run=%b expected 4 run=1", rem_sec, running);
    end
    @(posedge clk); #1;
    checks++;
    if (rem_sec !== 6'd3) begin
      errors++; $display("[TB] FAIL resume_partial: got %0d expected 3", rem_sec);
    end
    send(2'b11, 7'd0, 6'd0);
  endtask

  task automatic test_clamp;
    send(2'b00, 7'd120, 6'd63);
    checks++;
    if (rem_min !== 7'd99 || rem_sec !== 6'd59) begin
      errors++; $display("[TB] FAIL clamp_120_63: got %0d:%0d expected 99:59", rem_min, rem_sec);
    end
    send(2'b00, 7'd99, 6'd59);
    checks++;
    if (rem_min !== 7'd99 || rem_sec !== 6'd59 || cmd_err !== 1'b0) begin
      errors++; $display("[TB] FAIL clamp_edge: got %0d:%0d err=%b expected 99:59 err=0", rem_min, rem_sec, cmd_err);
    end
    send(2'b11, 7'd0, 6'd0);
  endtask

  task automatic test_illegal;
    send(2'b01, 7'd0, 6'd0);
    checks++;
    if (cmd_err !== 1'b1 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL start_idle: got err=%b run=%b expected err=1 run=0", cmd_err, running);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("[TB] FAIL err_one_cycle: got %b expected 0", cmd_err);
    end
    send(2'b10, 7'd0, 6'd0);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++; $display("[TB] FAIL pause_idle: got %b expected 1", cmd_err);
    end
    send(2'b00, 7'd0, 6'd3);
    send(2'b01, 7'd0, 6'd0);
    @(posedge clk);
    send(2'b00, 7'd5, 6'd5);
    checks++;
    if (cmd_err !== 1'b1 || rem_min !== 7'd0 || rem_sec !== 6'd3 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL load_in_run: got err=%b %0d:%0d run=%b expected err=1 0:3 run=1",
                         cmd_err, rem_min, rem_sec, running);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (rem_sec !== 6'd2 || cmd_err !== 1'b0) begin
      errors++; $display("[TB] FAIL run_unaffected: got sec=%0d err=%b expected 2 err=0", rem_sec, cmd_err);
    end
    send(2'b11, 7'd0, 6'd0);
    send(2'b00, 7'd0, 6'd0);
    send(2'b01, 7'd0, 6'd0);
    checks++;
    if (cmd_err !== 1'b1 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL start_zero: got err=%b run=%b expected err=1 run=0", cmd_err, running);
    end
    send(2'b11, 7'd0, 6'd0);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_no_err: got %b expected 0", cmd_err);
    end
  endtask

  task automatic test_clear_tick;
    int d0;
    int f0;
    d0 = done_count;
    send(2'b00, 7'd0, 6'd1);
    send(2'b01, 7'd0, 6'd0);
    repeat (3) @(posedge clk);
    f0 = flash_count;
    send(2'b11, 7'd0, 6'd0);
    checks++;
    if (rem_min !== 7'd0 || rem_sec !== 6'd0 || running !== 1'b0 || flash !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_vs_tick: got %0d:%0d run=%b fl=%b dn=%b expected 0:0 and all 0",
                         rem_min, rem_sec, running, flash, done);
    end
    repeat (10) @(posedge clk); #1;
    checks++;
    if (done_count - d0 !== 0 || flash_count - f0 !== 0) begin
      errors++; $display("[TB] FAIL clear_vs_tick_quiet: got done=%0d flash=%0d expected 0 0", done_count - d0, flash_count - f0);
    end
  endtask

  task automatic test_reset_mid_flash;
    int d0;
    int f0;
    send(2'b00, 7'd0, 6'd1);
    send(2'b01, 7'd0, 6'd0);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_flash_done: got %b expected 1", done);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (flash !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_flash_on: got %b expected 1", flash);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rem_min, rem_sec, running, flash, done, cmd_err, cmd_ready} !== 17'd0) begin
      errors++; $display("[TB] FAIL async_reset: got rem=%0d:%0d run=%b fl=%b dn=%b err=%b rdy=%b expected all 0",
                         rem_min, rem_sec, running, flash, done, cmd_err, cmd_ready);
    end
    @(negedge clk);
    @(negedge clk);
    d0 = done_count;
    f0 = flash_count;
    rst_n = 1'b1;
    repeat (30) @(posedge clk); #1;
    checks++;
    if (done_count - d0 !== 0 || flash_count - f0 !== 0 || cmd_ready !== 1'b1 || rem_sec !== 6'd0) begin
      errors++; $display("[TB] FAIL post_reset_quiet: got done=%0d flash=%0d rdy=%b sec=%0d expected 0 0 1 0",
                         done_count - d0, flash_count - f0, cmd_ready, rem_sec);
    end
    send(2'b01, 7'd0, 6'd0);
    checks++;
    if (cmd_err !== 1'b1 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_idle: got err=%b run=%b expected err=1 run=0", cmd_err, running);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_count();
    test_done_flash();
    test_pause();
    test_clamp();
    test_illegal();
    test_clear_tick();
    test_reset_mid_flash();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cook_timer_core.md
Name: cook_timer_core

Overview:
- Countdown responder for the oven front-panel controller. The controller issues LOAD/START/PAUSE/CLEAR commands over a valid/ready handshake.
- The block holds the set time in minutes:seconds and counts it down on an internal 1 s tick.
- It reports remaining time to the display path, signals completion, and drives the end-of-cook flash LED.

Parameters:
TICK_DIV, 100000000, clk cycles per count tick (1 s at 100 MHz); minimum 2
FLASH_TICKS, 10, ticks spent in the flash phase after reaching 0:00; minimum 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command can be accepted
cmd  input  2  00 LOAD, 01 START, 10 PAUSE, 11 CLEAR
load_min  input  7  minutes for LOAD, binary
load_sec  input  6  seconds for LOAD, binary
rem_min  output  7  remaining minutes
rem_sec  output  6  remaining seconds
running  output  1  high in RUN
flash  output  1  end-of-cook flash LED
done  output  1  one-cycle pulse when count reaches 0:00
cmd_err  output  1  one-cycle pulse when an accepted command is illegal in the current state

Behaviour:
- States: IDLE, LOADED, RUN, PAUSED, FLASH.
- Reset (async, rst_n=0):
  - state IDLE, set_min=set_sec=0, rem=0:00, prescaler=0, flash_cnt=0.
  - All outputs 0 except cmd_ready.
  - cmd_ready is 0 while rst_n=0 and 1 from the first clk after release.
- Handshake: a command is accepted on a rising edge with cmd_valid&&cmd_ready. cmd_ready is constantly 1 out of reset. Effects are visible on the cycle after acceptance.
- LOAD:
  - Legal in IDLE, LOADED, PAUSED.
  - Clamping: load_min>99 clamps to 99; load_sec>59 clamps to 59.
  - Stores the clamped values in set_min/set_sec and copies them to rem. Next state is LOADED.
  - In RUN or FLASH: cmd_err, no other effect.
- START:
  - Legal in LOADED when rem!=0:00. Prescaler cleared to 0, next state RUN.
  - Legal in PAUSED: prescaler is not cleared (resumes the partial second), next state RUN.
  - START with rem=0:00, or in IDLE, RUN, or FLASH: cmd_err, no state change.
- PAUSE:
  - Legal in RUN only: next state PAUSED, with prescaler and rem frozen.
  - Elsewhere: cmd_err.
- CLEAR: legal in every state. Next state IDLE, rem=0:00, set=0:00, flash=0, prescaler=0. Never errs.
- Tick:
  - The prescaler counts only in RUN and FLASH.
  - tick=1 when prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - The first decrement after a START from LOADED occurs exactly TICK_DIV cycles after acceptance.
- Decrement on tick in RUN:
  - rem_sec>0: rem_sec-1.
  - rem_sec==0 and rem_min>0: rem_min-1, rem_sec=59.
  - If the result is 0:00: done pulses on the same cycle rem becomes 0:00, next state FLASH, flash_cnt=0, prescaler=0, flash=1.
- FLASH:
  - On each tick: flash toggles and flash_cnt increments.
  - On the tick where flash_cnt==FLASH_TICKS-1: flash=0, rem reloads to set_min:set_sec, next state LOADED.
- running=1 only in RUN. done is never asserted outside the RUN→FLASH transition.
- Simultaneous events:
  - PAUSE accepted in the same cycle as a RUN tick: the decrement is applied, then PAUSED.
  - If that decrement reaches 0:00: FLASH wins, the PAUSE is ignored, no cmd_err.
  - CLEAR in the same cycle as any tick: CLEAR wins, no done, no decrement.
- Reset mid-operation: immediate return to reset values regardless of state, with no done or flash glitch after release.

Test Plan:
- Use TICK_DIV=4 and FLASH_TICKS=4 throughout.
- Reset then LOAD(1,2), START → rem 1:01 four cycles later. Sequence continues 1:00, 0:59 every 4 cycles. running=1.
- LOAD(0,2), START → 0:01, then 0:00 with done=1 for one cycle. flash=1, then toggles each tick for 4 ticks. Then returns to LOADED with rem=0:02, flash=0.
- LOAD(0,5), START, PAUSE two cycles after the first decrement → rem holds 0:04 for 20 cycles. START resumes, and the next decrement lands exactly 2 cycles later (partial second preserved).
- Illegal and clamped commands:
  - LOAD(120,63) → rem 99:59.
  - START from IDLE → cmd_err pulse, state IDLE.
  - LOAD during RUN → cmd_err, count unaffected.
  - START with 0:00 → cmd_err.
- CLEAR coincident with the tick that would reach 0:00 → IDLE, rem 0:00, no done pulse, flash=0.
- rst_n low mid-FLASH for 1 cycle → all outputs reset asynchronously (before the next clk edge). After release: state IDLE, no done pulse.
